handshake_sync_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one handshake_synchronizer among NUM_REQ requesters in src_clk domain.

---
 rtl/handshake_sync_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/handshake_sync_arbiter.sv
// Round-robin sequencer sharing one handshake synchronizer source port among NUM_REQ requesters.
// Optional watchdog: define HS_ARB_TIMEOUT_EN to build the sticky timeout_err counter.
module handshake_sync_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     src_clk,
  input  logic                     src_reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     sync_start,
  output logic [WIDTH-1:0]         sync_data,
  input  logic                     sync_ready,
  output logic                     timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_DONE} state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q, win_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic               busy_q, start_q;
  logic [WIDTH-1:0]   data_q;

  logic [IW-1:0]      win_d, ptr_d;
  logic               found_d;

  // Scan from the highest offset down so the nearest requester at/after ptr_q wins.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      int            p;
      logic [IW-1:0] idx;
      p   = int'(ptr_q) + i;
      idx = (p >= NUM_REQ) ? IW'(p - NUM_REQ) : IW'(p);
      if (req[idx]) begin
        win_d   = idx;
        found_d = 1'b1;
      end
    end
    ptr_d = (win_d == IW'(NUM_REQ-1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q  <= '0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (found_d && sync_ready) begin
          state_q <= S_LAUNCH;
          win_q   <= win_d;
          grant_q <= ONE << win_d;
          data_q  <= req_data[int'(win_d)*WIDTH +: WIDTH];
          ptr_q   <= ptr_d;
          busy_q  <= 1'b1;
          start_q <= 1'b1;
        end
        S_LAUNCH:    state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!sync_ready) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (sync_ready) begin
          state_q <= S_DONE;
          done_q  <= ONE << win_q;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign sync_start = start_q;
  assign sync_data  = data_q;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] tmo_cnt_q;
  logic          tmo_err_q;

  // Watchdog only flags; a live CDC handshake is never aborted.
  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else if (state_q == S_LAUNCH) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
                 tmo_cnt_q != CW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == CW'(TIMEOUT_CYCLES-1)) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_err    = 1'b0;
`endif

endmodule
